ppu_scanline_buffer: RTL and testbench
======================================

Name: ppu_scanline_buffer

Overview:
- Ping-pong scanline buffer between the palette lookup output and `vga_controller`.
- Captures one NES scanline of 256 six-bit palette indices from the render path. It replays that scanline scaled 2x horizontally and 2x vertically into the 640x480 VGA raster, with the 512-pixel image centred.
- Decouples render timing from VGA timing and provides `wr_ready` back-pressure to the render state machine.

Parameters:
- H_OFFSET, 64, first VGA column of the NES image
- NES_W, 256, NES pixels per scanline (bank depth)
- NES_H, 240, NES scanlines per frame
- BORDER_IDX, 6'h0F, palette index output outside the image or on underrun

Ports:
- VGA_CLK  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- frame_start  in  1  one-cycle pulse at start of frame (vsync edge); flushes buffer
- wr_line_start  in  1  one-cycle pulse; begins a new NES line in the current write bank
- wr_en  in  1  wr_data valid this cycle
- wr_data  in  6  palette index of next NES pixel, x ascending
- wr_ready  out  1  write bank free; render may start a line
- wr_line_done  out  1  one-cycle pulse when the 256th pixel of a line is written
- vga_x  in  10  current VGA column
- vga_y  in  10  current VGA row
- vga_active  in  1  display-enable from `vga_controller`
- pix_out  out  6  palette index for VGA, 1-cycle latency
- pix_valid  out  1  pix_out is image data, not border
- underrun  out  1  sticky: a line was due but its bank was not full
- overflow  out  1  sticky: a write was attempted with no free bank

Behaviour:
- Reset (async):
  - Outputs: `wr_ready`=1, `wr_line_done`=0, `pix_out`=BORDER_IDX, `pix_valid`=0, `underrun`=0, `overflow`=0.
  - Internal: `wb`=0, `rb`=0, `full`=2'b00, `wptr`=0, `filling`=0. RAM contents are don't-care.
- Storage: two banks, each 256x6, synchronous write and registered read.
- Write side:
  - `wr_ready` = !`full[wb]`.
  - `wr_line_start` with `wr_ready`=1: `filling`<=1, `wptr`<=0. With `wr_ready`=0 it is ignored and sets `overflow`.
  - `wr_en` with `filling`=1: write `bank[wb][wptr]`<=`wr_data`, then `wptr`++.
  - `wr_en` with `filling`=0 is dropped and sets `overflow`.
  - When `wptr`==255 and `wr_en`: `full[wb]`<=1, `wb` toggles, `filling`<=0, and `wr_line_done` pulses the next cycle.
- Read side:
  - In-image condition: `vga_active` && `vga_y`<2*NES_H && H_OFFSET<=`vga_x`<H_OFFSET+2*NES_W.
  - Read address: (`vga_x`-H_OFFSET)>>1. Each NES pixel occupies 2 VGA columns.
  - Latency: `pix_out`/`pix_valid` for the (`vga_x`,`vga_y`) presented in cycle N are valid in cycle N+1.
  - When the condition holds and `full[rb]`=1: `pix_out`=`bank[rb][addr]`, `pix_valid`=1.
  - When the condition holds and `full[rb]`=0: `pix_out`=BORDER_IDX, `pix_valid`=0, `underrun`<=1.
  - Outside the condition: `pix_out`=BORDER_IDX, `pix_valid`=0.
- Line release: each NES line is shown on VGA rows 2k and 2k+1. When `vga_y`[0]=1 && `vga_x`==H_OFFSET+2*NES_W-1 && `vga_active`:
  - if `full[rb]`, then `full[rb]`<=0;
  - `rb` toggles in either case, so an underrun does not stall the pipeline.
- Simultaneous events:
  - Write completion and release in the same cycle update different bank bits; both take effect.
  - If both target the same bank (only possible after underrun), release clears the bit first and the write sets it, so `full` ends at 1.
- `frame_start`:
  - Has priority over everything except reset.
  - Sets `full`<=0, `wb`<=0, `rb`<=0, `filling`<=0, `wptr`<=0.
  - Clears neither `underrun` nor `overflow`; only reset clears those.
  - A line in progress is discarded, and later `wr_en` is dropped until the next `wr_line_start`.
- Vertical blank: `vga_y`>=480 generates no reads and no releases. The write side may pre-fill both banks.

Test Plan:
- Reset, `frame_start`, then write line 0 = {0..63 repeating} -> `wr_line_done` pulses one cycle after the 256th write; `wr_ready`=1 (bank1 free). Write line 1 -> `wr_ready`=0.
- With both banks full, sweep VGA row 0, x=0..799 -> `pix_out`=0x0F for x<64; at x=64,65 it is 0, at x=66,67 it is 1; at x=575 it is 63; for x>=576 it is 0x0F, each one cycle late. `pix_valid` high exactly 512 cycles.
- Rows 0 and 1 -> identical data. After row 1 x=575, `wr_ready` rises; row 2 shows line 1.
- No writes, sweep row 0 -> `pix_out`=0x0F throughout, `underrun`=1 from the cycle after x=64. At row 1 end, `rb` toggles.
- While `wr_ready`=0, issue `wr_line_start` plus 5 `wr_en` -> `overflow`=1, stored data unchanged.
- Assert `frame_start` after 100 pixels of a line -> `full`=00, `wr_ready`=1. The next 10 `wr_en` without `wr_line_start` are dropped, and `overflow` sets. Assert reset mid-line -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ppu_scanline_buffer_if.sv
// Render-side write handshake into the scanline buffer.
// The render state machine is the master; the buffer is the slave.
interface ppu_scanline_buffer_if;
  logic       wr_line_start;
  logic       wr_en;
  logic [5:0] wr_data;
  logic       wr_ready;
  logic       wr_line_done;

  modport master (
    output wr_line_start, wr_en, wr_data,
    input  wr_ready, wr_line_done
  );

  modport slave (
    input  wr_line_start, wr_en, wr_data,
    output wr_ready, wr_line_done
  );
endinterface

// File: rtl/ppu_scanline_buffer.sv
// Ping-pong buffer holding NES scanlines of palette indices. Each line is replayed
// 2x wide and 2x tall, centred in the 640x480 VGA raster.
module ppu_scanline_buffer #(
  parameter int         H_OFFSET   = 64,
  parameter int         NES_W      = 256,
  parameter int         NES_H      = 240,
  parameter logic [5:0] BORDER_IDX = 6'h0F
) (
  input  logic                        VGA_CLK,
  input  logic                        reset,
  input  logic                        frame_start,
  ppu_scanline_buffer_if.slave        wr,
  input  logic [9:0]                  vga_x,
  input  logic [9:0]                  vga_y,
  input  logic                        vga_active,
  output logic [5:0]                  pix_out,
  output logic                        pix_valid,
  output logic                        underrun,
  output logic                        overflow
);

  localparam int AW    = $clog2(NES_W);
  localparam int X_END = H_OFFSET + 2 * NES_W;
  localparam int Y_END = 2 * NES_H;

  logic [5:0]    mem [2*NES_W];
  logic [5:0]    rd_data;
  logic          rd_hit;
  logic          wb, rb, filling;
  logic [1:0]    full, full_next;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rd_addr;
  logic          wr_fire, wr_last, in_img, release_line;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_fire      = wr.wr_en && filling;
    wr_last      = wr_fire && (wptr == AW'(NES_W - 1));
    rd_addr      = AW'((vga_x - 10'(H_OFFSET)) >> 1);
    in_img       = vga_active && (vga_y < 10'(Y_END)) &&
                   (vga_x >= 10'(H_OFFSET)) && (vga_x < 10'(X_END));
    release_line = vga_active && vga_y[0] && (vga_y < 10'(Y_END)) &&
                   (vga_x == 10'(X_END - 1));
    // Release clears before completion sets, so a shared bank ends full.
    full_next = full;
    if (release_line) full_next[rb] = 1'b0;
    if (wr_last)      full_next[wb] = 1'b1;
  end

  assign wr.wr_ready = !full[wb];
  assign pix_out     = rd_hit ? rd_data : BORDER_IDX;
  assign pix_valid   = rd_hit;

  // NOTE: the storage array is deliberately left out of reset; its contents are never used before a line fills it.
  always_ff @(posedge VGA_CLK) begin
    if (wr_fire && !frame_start) mem[{wb, wptr}] <= wr.wr_data;
    rd_data <= mem[{rb, rd_addr}];
  end

  // NOTE: all state here uses non-blocking assignments, so the order of statements never changes what is sampled.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      wb              <= 1'b0;
      rb              <= 1'b0;
      full            <= 2'b00;
      wptr            <= '0;
      filling         <= 1'b0;
      wr.wr_line_done <= 1'b0;
      rd_hit          <= 1'b0;
      underrun        <= 1'b0;
      overflow        <= 1'b0;
    end else if (frame_start) begin
      // Flush both banks; the sticky error flags survive until reset.
      wb              <= 1'b0;
      rb              <= 1'b0;
      full            <= 2'b00;
      wptr            <= '0;
      filling         <= 1'b0;
      wr.wr_line_done <= 1'b0;
      rd_hit          <= 1'b0;
    end else begin
      full            <= full_next;
      wr.wr_line_done <= wr_last;
      rd_hit          <= in_img && full[rb];
      if (in_img && !full[rb]) underrun <= 1'b1;
      // The read bank advances even on underrun so the pipeline never stalls.
      if (release_line) rb <= ~rb;

      if (wr_fire) begin
        wptr <= wptr + 1'b1;
        if (wr_last) begin
          wb      <= ~wb;
          filling <= 1'b0;
        end
      end else if (wr.wr_en) begin
        overflow <= 1'b1;
      end

      if (wr.wr_line_start) begin
        if (wr.wr_ready) begin
          filling <= 1'b1;
          wptr    <= '0;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_scanline_buffer.sv
// Scoreboard bench for ppu_scanline_buffer: stimulus queues expected pixels and
// line-done pulses, a negedge monitor pops and compares them.
module tb_ppu_scanline_buffer;

  logic       VGA_CLK = 1'b0;
  logic       reset;
  logic       frame_start;
  logic [9:0] vga_x, vga_y;
  logic       vga_active;
  logic [5:0] pix_out;
  logic       pix_valid, underrun, overflow;

  ppu_scanline_buffer_if wif ();

  ppu_scanline_buffer dut (
    .VGA_CLK     (VGA_CLK),
    .reset       (reset),
    .frame_start (frame_start),
    .wr          (wif.slave),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_active  (vga_active),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  typedef struct {
    logic [6:0] exp;
    int         due;
    int         x;
    int         y;
  } pix_t;

  pix_t pq[$];
  int   dq[$];
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   valid_cnt = 0;

  always @(posedge VGA_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Test lines: each is a distinct, easily hand-checked pattern.
  function automatic logic [5:0] line_val(input int id, input int i);
    case (id)
      0:       return 6'(i % 64);
      1:       return 6'((i + 32) % 64);
      2:       return 6'((i ^ 42) & 63);
      3:       return 6'(63 - (i % 64));
      4:       return 6'((i * 5) % 64);
      default: return 6'h00;
    endcase
  endfunction

  always @(negedge VGA_CLK) begin
    if (pix_valid) valid_cnt++;
    while (pq.size() > 0 && pq[0].due < cyc) begin
      check("pix_missed_slot", pq[0].due, cyc);
      void'(pq.pop_front());
    end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      pix_t e;
      e = pq.pop_front();
      check($sformatf("pix y%0d x%0d {valid,idx}", e.y, e.x), {pix_valid, pix_out}, e.exp);
    end
    if (wif.wr_line_done) begin
      if (dq.size() == 0) check("wr_line_done_unexpected", wif.wr_line_done, 0);
      else                check("wr_line_done_cycle", cyc, dq.pop_front());
    end
  end

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic write_line(input int id, input int n, input bit expect_done);
    wif.wr_line_start = 1'b1;
    tick();
    wif.wr_line_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      wif.wr_en   = 1'b1;
      wif.wr_data = line_val(id, i);
      if (expect_done && i == 255) dq.push_back(cyc + 1);
      tick();
    end
    wif.wr_en = 1'b0;
  endtask

  // src >= 0: the row must show line 'src'; src < 0: border only.
  task automatic sweep_row(input int y, input int src, input bit chk_ur);
    valid_cnt = 0;
    for (int x = 0; x < 800; x++) begin
      pix_t e;
      bit   in_img;
      vga_x      = 10'(x);
      vga_y      = 10'(y);
      vga_active = (x < 640);
      in_img     = (x < 640) && (x >= 64) && (x < 576);
      e.exp = (in_img && src >= 0) ? {1'b1, line_val(src, (x - 64) / 2)} : {1'b0, 6'h0F};
      e.due = cyc + 1;
      e.x   = x;
      e.y   = y;
      pq.push_back(e);
      tick();
      if (chk_ur && x == 63) check("underrun_before_x64", underrun, 0);
      if (chk_ur && x == 64) check("underrun_after_x64", underrun, 1);
    end
    vga_active = 1'b0;
    vga_x      = 10'd0;
    tick();
    tick();
    check($sformatf("pix_valid_count row%0d", y), valid_cnt, (src >= 0) ? 512 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    frame_start       = 1'b0;
    vga_x             = '0;
    vga_y             = '0;
    vga_active        = 1'b0;
    wif.wr_line_start = 1'b0;
    wif.wr_en         = 1'b0;
    wif.wr_data       = '0;

    #12;
    check("rst wr_ready", wif.wr_ready, 1);
    check("rst wr_line_done", wif.wr_line_done, 0);
    check("rst pix_out", pix_out, 6'h0F);
    check("rst pix_valid", pix_valid, 0);
    check("rst underrun", underrun, 0);
    check("rst overflow", overflow, 0);
    tick();
    reset = 1'b0;
    tick();
    pulse_frame_start();

    // Fill both banks, then replay them.
    write_line(0, 256, 1);
    check("wr_ready after line0", wif.wr_ready, 1);
    write_line(1, 256, 1);
    check("wr_ready after line1", wif.wr_ready, 0);
    sweep_row(0, 0, 0);
    sweep_row(1, 0, 0);
    check("wr_ready after row1 release", wif.wr_ready, 1);
    sweep_row(2, 1, 0);
    sweep_row(3, 1, 0);

    // Empty buffer: border output, sticky underrun, read bank still advances.
    check("underrun before starve", underrun, 0);
    sweep_row(4, -1, 1);
    sweep_row(5, -1, 0);
    write_line(2, 256, 1);
    sweep_row(6, -1, 0);
    sweep_row(7, -1, 0);
    write_line(3, 256, 1);
    check("wr_ready both full", wif.wr_ready, 0);

    // Writes with no free bank are dropped.
    check("overflow before", overflow, 0);
    write_line(4, 5, 0);
    check("overflow after blocked line", overflow, 1);
    sweep_row(8, 2, 0);
    sweep_row(9, 2, 0);
    check("wr_ready after row9 release", wif.wr_ready, 1);

    // Asynchronous reset in the middle of a line.
    vga_x      = 10'd100;
    vga_y      = 10'd10;
    vga_active = 1'b1;
    write_line(4, 100, 0);
    check("pre-reset pix_valid", pix_valid, 1);
    check("pre-reset pix_out", pix_out, line_val(3, 18));
    #2;
    reset = 1'b1;
    #1;
    check("mid rst wr_ready", wif.wr_ready, 1);
    check("mid rst wr_line_done", wif.wr_line_done, 0);
    check("mid rst pix_out", pix_out, 6'h0F);
    check("mid rst pix_valid", pix_valid, 0);
    check("mid rst underrun", underrun, 0);
    check("mid rst overflow", overflow, 0);
    vga_active = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // frame_start discards a partial line and flushes the full bank.
    pulse_frame_start();
    write_line(0, 256, 1);
    write_line(1, 100, 0);
    pulse_frame_start();
    check("wr_ready after frame_start", wif.wr_ready, 1);
    check("overflow before dropped writes", overflow, 0);
    for (int i = 0; i < 10; i++) begin
      wif.wr_en   = 1'b1;
      wif.wr_data = 6'(i);
      tick();
    end
    wif.wr_en = 1'b0;
    check("overflow after dropped writes", overflow, 1);
    check("underrun before flushed row", underrun, 0);
    sweep_row(0, -1, 1);
    write_line(4, 256, 1);
    check("wr_ready after refill", wif.wr_ready, 1);
    sweep_row(2, 4, 0);

    repeat (4) tick();
    check("pixel queue drained", pq.size(), 0);
    check("line_done queue drained", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
